prel1_tag_buffer: RTL and testbench

//  Downstream stage of the pre-L1 counter. Watches the 10-bit pre-L1 count, and on every increment

---
 rtl/prel1_tag_buffer_pkg.sv | 17 +
 rtl/prel1_tag_buffer_if.sv | 25 ++
 rtl/prel1_tag_buffer_fifo.sv | 51 +++++
 rtl/prel1_tag_buffer.sv | 131 +++++++++++++
 tb/tb_prel1_tag_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prel1_tag_buffer_pkg.sv
// prel1_pkg: shared widths, entry layout and output FSM states
// for the pre-L1 tag buffer.
package prel1_pkg;
  localparam int PREL1_CNT_W = 10;
  localparam logic [PREL1_CNT_W-1:0] PREL1_CNT_IDLE = 10'h3FF;
  localparam int PREL1_TS_W = 16;

  typedef struct packed {
    logic [PREL1_CNT_W-1:0] cnt;
    logic [PREL1_TS_W-1:0]  ts;
  } prel1_entry_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;
endpackage

// File: rtl/prel1_tag_buffer_if.sv
// prel1_tag_buffer_if: L1 decision input and accepted-entry
// output handshakes.
interface prel1_tag_buffer_if #(
  parameter int TS_W = 16
);
  import prel1_pkg::*;

  logic                   l1_valid;
  logic                   l1_accept;
  logic                   l1_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [PREL1_CNT_W-1:0] out_cnt;
  logic [TS_W-1:0]        out_ts;

  modport master (
    output l1_valid, l1_accept, out_ready,
    input  l1_ready, out_valid, out_cnt, out_ts
  );

  modport slave (
    input  l1_valid, l1_accept, out_ready,
    output l1_ready, out_valid, out_cnt, out_ts
  );
endinterface

// File: rtl/prel1_tag_buffer_fifo.sv
// prel1_tag_fifo: synchronous circular FIFO with
// first-word-fall-through head and occupancy count.
module prel1_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = fill == (AW+1)'(DEPTH);
  assign empty   = fill == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp   <= '0;
      rp   <= '0;
      fill <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      if (do_push && !do_pop)
        fill <= fill + (AW+1)'(1);
      else if (!do_push && do_pop)
        fill <= fill - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush)
      mem[wp] <= din;
  end
endmodule

// File: rtl/prel1_tag_buffer.sv
// prel1_tag_buffer: queues {count, timestamp} per pre-L1 increment
// until its L1 decision. Optional PREL1_AGE_CHECK_EN auto-rejects stale heads.
module prel1_tag_buffer
  import prel1_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TS_W    = PREL1_TS_W,
  parameter int MAX_AGE = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   LIVE,
  input  logic [PREL1_CNT_W-1:0] cnt_in,
  prel1_tag_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   ovf_sticky,
  output logic                   seq_sticky,
  output logic [7:0]             drop_cnt
`ifdef PREL1_AGE_CHECK_EN
  ,
  output logic                   age_sticky
`endif
);
  localparam int EW = PREL1_CNT_W + TS_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_AGE < 1)
  begin : g_bad_cfg
    $error("prel1_tag_buffer: bad DEPTH or MAX_AGE");
  end

  logic [TS_W-1:0]        ts;
  logic [PREL1_CNT_W-1:0] cnt_prev;
  logic [EW-1:0]          head;
  logic [PREL1_CNT_W-1:0] head_cnt;
  logic [TS_W-1:0]        head_ts;
  logic [PREL1_CNT_W-1:0] out_cnt_q;
  logic [TS_W-1:0]        out_ts_q;
  out_state_t             state;
  logic evt, seq_err, full, empty;
  logic push, drop, dec, take, pop, age_pop;
  logic [1:0]             drop_inc;
  logic [8:0]             drop_sum;

  assign evt     = LIVE && (cnt_in != cnt_prev);
  assign seq_err = evt && (cnt_in != cnt_prev + PREL1_CNT_W'(1));
  assign push    = evt && !full;
  assign drop    = evt && full;

  assign bus.l1_ready = LIVE && !empty &&
                        (state == OUT_EMPTY || bus.out_ready);
  assign dec  = bus.l1_valid && bus.l1_ready;
  assign take = dec && bus.l1_accept;

`ifdef PREL1_AGE_CHECK_EN
  logic [TS_W-1:0] age;
  assign age     = ts - head_ts;
  assign age_pop = LIVE && !empty && !dec && (age > TS_W'(MAX_AGE));
`else
  assign age_pop = 1'b0;
`endif

  assign pop      = dec || age_pop;
  assign head_cnt = head[EW-1 -: PREL1_CNT_W];
  assign head_ts  = head[TS_W-1:0];

  // overflow drop and auto-reject can land in the same cycle
  assign drop_inc = {1'b0, drop} + {1'b0, age_pop};
  assign drop_sum = {1'b0, drop_cnt} + 9'(drop_inc);

  prel1_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!LIVE),
    .push  (push),
    .pop   (pop),
    .din   ({cnt_in, ts}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      cnt_prev   <= PREL1_CNT_IDLE;
      state      <= OUT_EMPTY;
      out_cnt_q  <= '0;
      out_ts_q   <= '0;
      ovf_sticky <= 1'b0;
      seq_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (!LIVE) begin
      ts       <= '0;
      cnt_prev <= PREL1_CNT_IDLE;
      state    <= OUT_EMPTY;
    end else begin
      ts       <= ts + TS_W'(1);
      cnt_prev <= cnt_in;
      if (seq_err) seq_sticky <= 1'b1;
      if (drop)    ovf_sticky <= 1'b1;
      if (drop_inc != 2'd0)
        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      unique case (state)
        OUT_EMPTY: if (take) state <= OUT_FULL;
        OUT_FULL:  if (bus.out_ready && !take) state <= OUT_EMPTY;
        default:   state <= OUT_EMPTY;
      endcase
      if (take) begin
        out_cnt_q <= head_cnt;
        out_ts_q  <= head_ts;
      end
    end
  end

`ifdef PREL1_AGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      age_sticky <= 1'b0;
    else if (age_pop)
      age_sticky <= 1'b1;
  end
`endif

  assign bus.out_valid = state == OUT_FULL;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_ts    = out_ts_q;
endmodule

// File: tb/tb_prel1_tag_buffer.sv
// tb_prel1_tag_buffer: directed vector table plus hand sequences
// for overflow, saturation and (with PREL1_AGE_CHECK_EN) ageing.
module tb_prel1_tag_buffer;
  import prel1_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TS_W    = 16;
  localparam int MAX_AGE = 1023;

  logic       clk = 1'b0;
  logic       rst;
  logic       live;
  logic [9:0] cnt_in;
  logic [4:0] fill;
  logic       ovf_sticky;
  logic       seq_sticky;
  logic [7:0] drop_cnt;
`ifdef PREL1_AGE_CHECK_EN
  logic       age_sticky;
`endif

  int checks = 0;
  int errors = 0;

  prel1_tag_buffer_if #(.TS_W(TS_W)) bus ();

  prel1_tag_buffer #(
    .DEPTH   (DEPTH),
    .TS_W    (TS_W),
    .MAX_AGE (MAX_AGE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .LIVE       (live),
    .cnt_in     (cnt_in),
    .bus        (bus),
    .fill       (fill),
    .ovf_sticky (ovf_sticky),
    .seq_sticky (seq_sticky),
    .drop_cnt   (drop_cnt)
`ifdef PREL1_AGE_CHECK_EN
    ,
    .age_sticky (age_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [9:0]  cnt;
    logic        lv;
    logic        la;
    logic        ordy;
    logic        lrdy;
    logic        ov;
    logic [9:0]  ocnt;
    logic [15:0] ots;
    logic [4:0]  fill;
    logic        seq;
    logic        co;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    int live_i, int cnt_i, int lv_i, int la_i, int ordy_i,
    int lrdy_i, int ov_i, int ocnt_i, int ots_i, int fill_i,
    int seq_i, int co_i);
    vec_t v;
    v.live = live_i != 0;
    v.cnt  = 10'(cnt_i);
    v.lv   = lv_i != 0;
    v.la   = la_i != 0;
    v.ordy = ordy_i != 0;
    v.lrdy = lrdy_i != 0;
    v.ov   = ov_i != 0;
    v.ocnt = 10'(ocnt_i);
    v.ots  = 16'(ots_i);
    v.fill = 5'(fill_i);
    v.seq  = seq_i != 0;
    v.co   = co_i != 0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    live          = v.live;
    cnt_in        = v.cnt;
    bus.l1_valid  = v.lv;
    bus.l1_accept = v.la;
    bus.out_ready = v.ordy;
  endtask

  initial begin
    rst           = 1'b1;
    live          = 1'b0;
    cnt_in        = 10'h3FF;
    bus.l1_valid  = 1'b0;
    bus.l1_accept = 1'b0;
    bus.out_ready = 1'b0;

    // live cnt lv la ordy | lrdy ov ocnt ots fill seq co
    vt.push_back(mk(1, 'h3FF, 0, 0, 0,  0, 0, 'h000,  0, 0, 0, 1));
    vt.push_back(mk(1, 'h000, 0, 0, 0,  0, 0, 'h000,  0, 0, 0, 1));
    vt.push_back(mk(1, 'h000, 1, 1, 1,  1, 0, 'h000,  0, 1, 0, 1));
    vt.push_back(mk(1, 'h001, 0, 0, 0,  0, 1, 'h000,  1, 0, 0, 1));
    vt.push_back(mk(1, 'h001, 1, 1, 1,  1, 1, 'h000,  1, 1, 0, 1));
    vt.push_back(mk(1, 'h001, 0, 0, 1,  0, 1, 'h001,  3, 0, 0, 1));
    vt.push_back(mk(1, 'h002, 0, 0, 1,  0, 0, 0,      0, 0, 0, 0));
    vt.push_back(mk(1, 'h003, 0, 0, 1,  1, 0, 0,      0, 1, 0, 0));
    vt.push_back(mk(1, 'h004, 1, 0, 1,  1, 0, 0,      0, 2, 0, 0));
    vt.push_back(mk(1, 'h004, 1, 1, 1,  1, 0, 0,      0, 2, 0, 0));
    vt.push_back(mk(1, 'h004, 1, 0, 1,  1, 1, 'h003,  7, 1, 0, 1));
    vt.push_back(mk(1, 'h004, 1, 1, 1,  0, 0, 0,      0, 0, 0, 0));
    vt.push_back(mk(1, 'h005, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0));
    vt.push_back(mk(1, 'h006, 1, 1, 0,  1, 0, 0,      0, 1, 0, 0));
    vt.push_back(mk(1, 'h006, 1, 1, 0,  0, 1, 'h005, 12, 1, 0, 1));
    vt.push_back(mk(1, 'h006, 1, 1, 0,  0, 1, 'h005, 12, 1, 0, 1));
    vt.push_back(mk(1, 'h006, 1, 1, 1,  1, 1, 'h005, 12, 1, 0, 1));
    vt.push_back(mk(1, 'h006, 0, 0, 1,  0, 1, 'h006, 13, 0, 0, 1));
    vt.push_back(mk(1, 'h008, 0, 0, 1,  0, 0, 0,      0, 0, 0, 0));
    vt.push_back(mk(1, 'h009, 0, 0, 1,  1, 0, 0,      0, 1, 1, 0));
    vt.push_back(mk(1, 'h00A, 0, 0, 1,  1, 0, 0,      0, 2, 1, 0));
    vt.push_back(mk(1, 'h00B, 1, 1, 1,  1, 0, 0,      0, 3, 1, 0));
    vt.push_back(mk(1, 'h00C, 0, 0, 0,  0, 1, 'h008, 18, 3, 1, 1));
    vt.push_back(mk(0, 'h3FF, 0, 0, 0,  0, 1, 'h008, 18, 4, 1, 1));
    vt.push_back(mk(0, 'h3FF, 0, 0, 0,  0, 0, 0,      0, 0, 1, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst fill", 32'(fill), 0);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_cnt", 32'(bus.out_cnt), 0);
    chk("rst out_ts", 32'(bus.out_ts), 0);
    chk("rst l1_ready", 32'(bus.l1_ready), 0);
    chk("rst ovf", 32'(ovf_sticky), 0);
    chk("rst seq", 32'(seq_sticky), 0);
    chk("rst drop", 32'(drop_cnt), 0);
    cyc();
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i]);
      @(negedge clk);
      chk($sformatf("r%0d l1_ready", i), 32'(bus.l1_ready), 32'(vt[i].lrdy));
      chk($sformatf("r%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].ov));
      chk($sformatf("r%0d fill", i), 32'(fill), 32'(vt[i].fill));
      chk($sformatf("r%0d seq", i), 32'(seq_sticky), 32'(vt[i].seq));
      chk($sformatf("r%0d ovf", i), 32'(ovf_sticky), 0);
      chk($sformatf("r%0d drop", i), 32'(drop_cnt), 0);
      if (vt[i].co) begin
        chk($sformatf("r%0d out_cnt", i), 32'(bus.out_cnt), 32'(vt[i].ocnt));
        chk($sformatf("r%0d out_ts", i), 32'(bus.out_ts), 32'(vt[i].ots));
      end
      cyc();
    end

    // overflow: 18 pushes into 16 slots, then a push racing a pop
    live          = 1'b1;
    cnt_in        = 10'h3FF;
    bus.l1_valid  = 1'b0;
    bus.l1_accept = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    for (int k = 0; k < 18; k++) begin
      cnt_in = 10'(k);
      cyc();
    end
    @(negedge clk);
    chk("ovf fill", 32'(fill), 16);
    chk("ovf sticky", 32'(ovf_sticky), 1);
    chk("ovf drop", 32'(drop_cnt), 2);
    chk("ovf l1_ready", 32'(bus.l1_ready), 1);
    cnt_in        = 10'h012;
    bus.l1_valid  = 1'b1;
    bus.l1_accept = 1'b1;
    cyc();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("order %0d out_valid", k), 32'(bus.out_valid), 1);
      chk($sformatf("order %0d out_cnt", k), 32'(bus.out_cnt), k);
      cyc();
    end
    bus.l1_valid = 1'b0;
    @(negedge clk);
    chk("drain out_valid", 32'(bus.out_valid), 0);
    chk("drain fill", 32'(fill), 0);
    chk("drain drop", 32'(drop_cnt), 3);

    // drop counter saturation
    for (int k = 1; k <= 267; k++) begin
      cnt_in = 10'(18 + k);
      cyc();
    end
    @(negedge clk);
    chk("sat drop FE", 32'(drop_cnt), 32'h0FE);
    chk("sat fill", 32'(fill), 16);
    for (int k = 268; k <= 276; k++) begin
      cnt_in = 10'(18 + k);
      cyc();
    end
    @(negedge clk);
    chk("sat drop FF", 32'(drop_cnt), 32'h0FF);
    live   = 1'b0;
    cnt_in = 10'h3FF;
    cyc();

`ifdef PREL1_AGE_CHECK_EN
    rst = 1'b1;
    cyc();
    rst  = 1'b0;
    live = 1'b1;
    cyc();
    cnt_in = 10'h000;
    cyc();
    repeat (MAX_AGE) cyc();
    @(negedge clk);
    chk("age pre fill", 32'(fill), 1);
    chk("age pre sticky", 32'(age_sticky), 0);
    cyc();
    @(negedge clk);
    chk("age post fill", 32'(fill), 0);
    chk("age post sticky", 32'(age_sticky), 1);
    chk("age post drop", 32'(drop_cnt), 1);
    chk("age post out_valid", 32'(bus.out_valid), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
